// File: rtl/fb_pixel_packer_if.sv
// Pixel stream and framebuffer write-port bundle for fb_pixel_packer.
// master drives the pixel stream; slave is the packer.
interface fb_pixel_packer_if #(
    parameter int ADDR_W = 15
);
    logic              pix_valid;
    logic              pix_data;
    logic              pix_sof;
    logic              pix_ready;
    logic              clear_req;
    logic              clear_value;
    logic              fb_write;
    logic [ADDR_W-1:0] fb_address;
    logic [31:0]       fb_writedata;
    logic              busy;
    logic              frame_done;
    logic              clear_done;
    logic              sof_err;

    modport master (
        output pix_valid, pix_data, pix_sof, clear_req, clear_value,
        input  pix_ready, fb_write, fb_address, fb_writedata,
        input  busy, frame_done, clear_done, sof_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, clear_req, clear_value,
        output pix_ready, fb_write, fb_address, fb_writedata,
        output busy, frame_done, clear_done, sof_err
    );
endinterface

// File: rtl/fb_pixel_packer.sv
// Packs a 1-bpp pixel stream into 32-bit framebuffer words and
// provides a full-frame hardware clear.
module fb_pixel_packer #(
    parameter int WORDS  = 9600,
    parameter int ADDR_W = 15
) (
    input logic              clk50,
    input logic              reset,
    fb_pixel_packer_if.slave bus
);
    typedef enum logic {STREAM, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] clr_cnt;
    logic [31:0]       shreg;
    logic              fill;

    logic              accept;
    logic              sof_ok;
    logic [31:0]       word_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [ADDR_W-1:0] clr_nx;

    assign bus.pix_ready = (state == STREAM) && !bus.clear_req;
    assign accept  = bus.pix_valid && bus.pix_ready;
    assign sof_ok  = (bit_cnt == 5'd0) && (addr == '0);
    assign addr_nx = (addr == LAST) ? '0 : addr + ADDR_W'(1);
    assign clr_nx  = clr_cnt + ADDR_W'(1);

    // Current word including the pixel being accepted this cycle
    always_comb begin
        word_nx          = shreg;
        word_nx[bit_cnt] = bus.pix_data;
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state            <= STREAM;
            bit_cnt          <= '0;
            addr             <= '0;
            clr_cnt          <= '0;
            shreg            <= '0;
            fill             <= 1'b0;
            bus.fb_write     <= 1'b0;
            bus.fb_address   <= '0;
            bus.fb_writedata <= '0;
            bus.busy         <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.clear_done   <= 1'b0;
            bus.sof_err      <= 1'b0;
        end else begin
            bus.fb_write   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.clear_done <= 1'b0;
            bus.sof_err    <= 1'b0;
            unique case (state)
                STREAM: begin
                    if (bus.clear_req) begin
                        state            <= CLEAR;
                        fill             <= bus.clear_value;
                        clr_cnt          <= '0;
                        bit_cnt          <= '0;
                        addr             <= '0;
                        shreg            <= '0;
                        bus.busy         <= 1'b1;
                        bus.fb_write     <= 1'b1;
                        bus.fb_address   <= '0;
                        bus.fb_writedata <= {32{bus.clear_value}};
                        bus.clear_done   <= (WORDS == 1);
                    end else if (accept) begin
                        if (bus.pix_sof && !sof_ok) begin
                            // Resync: drop the partial word, restart frame
                            bus.sof_err <= 1'b1;
                            addr        <= '0;
                            shreg       <= {31'b0, bus.pix_data};
                            bit_cnt     <= 5'd1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                bus.fb_write     <= 1'b1;
                                bus.fb_address   <= addr;
                                bus.fb_writedata <= word_nx;
                                bus.frame_done   <= (addr == LAST);
                                addr             <= addr_nx;
                                shreg            <= '0;
                            end else begin
                                shreg <= word_nx;
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state    <= STREAM;
                        bus.busy <= 1'b0;
                    end else begin
                        clr_cnt          <= clr_nx;
                        bus.fb_write     <= 1'b1;
                        bus.fb_address   <= clr_nx;
                        bus.fb_writedata <= {32{fill}};
                        bus.clear_done   <= (clr_nx == LAST);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_pixel_packer.sv
// Randomized and directed bench for fb_pixel_packer against a
// pixel-position reference model.
module tb_fb_pixel_packer;
    localparam int WORDS  = 40;
    localparam int ADDR_W = 15;
    localparam int FRAME  = WORDS * 32;

    logic clk50 = 1'b0;
    logic reset;

    fb_pixel_packer_if #(.ADDR_W(ADDR_W)) pif ();

    fb_pixel_packer #(
        .WORDS (WORDS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk50(clk50),
        .reset(reset),
        .bus  (pif)
    );

    always #5 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;

    // Reference model: frame-relative pixel position plus clear progress
    int                m_pos;
    logic [31:0]       m_word;
    bit                m_clearing;
    int                m_ci;
    bit                m_fill;
    logic              e_write, e_busy, e_fd, e_cd, e_se;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_data;

    int wr_cnt, fd_cnt, cd_cnt, se_cnt, busy_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_word = '0; m_clearing = 0; m_ci = 0; m_fill = 0;
        e_write = 0; e_busy = 0; e_fd = 0; e_cd = 0; e_se = 0;
        e_addr = '0; e_data = '0;
    endtask

    task automatic clr_counts();
        wr_cnt = 0; fd_cnt = 0; cd_cnt = 0; se_cnt = 0; busy_cnt = 0;
    endtask

    task automatic cyc(input bit v, input bit d, input bit s,
                       input bit c, input bit cv);
        pif.pix_valid   = v;
        pif.pix_data    = d;
        pif.pix_sof     = s;
        pif.clear_req   = c;
        pif.clear_value = cv;
        #1;
        chk("pix_ready", pif.pix_ready, !m_clearing && !c);
        e_write = 0; e_fd = 0; e_cd = 0; e_se = 0;
        if (m_clearing) begin
            if (m_ci == WORDS - 1) begin
                m_clearing = 0;
                e_busy = 0;
            end else begin
                m_ci++;
                e_write = 1;
                e_addr = ADDR_W'(m_ci);
                e_data = {32{m_fill}};
                e_cd = (m_ci == WORDS - 1);
            end
        end else if (c) begin
            m_clearing = 1; m_ci = 0; m_fill = cv;
            m_pos = 0; m_word = '0;
            e_write = 1; e_addr = '0; e_data = {32{cv}};
            e_busy = 1; e_cd = (WORDS == 1);
        end else if (v) begin
            if (s && m_pos != 0) begin
                e_se = 1; m_pos = 0; m_word = '0;
            end
            m_word[m_pos % 32] = d;
            m_pos++;
            if (m_pos % 32 == 0) begin
                e_write = 1;
                e_addr = ADDR_W'(m_pos / 32 - 1);
                e_data = m_word;
                m_word = '0;
                if (m_pos == FRAME) begin
                    e_fd = 1;
                    m_pos = 0;
                end
            end
        end
        @(posedge clk50);
        #1;
        chk("fb_write", pif.fb_write, e_write);
        chk("fb_address", pif.fb_address, e_addr);
        chk("fb_writedata", pif.fb_writedata, e_data);
        chk("busy", pif.busy, e_busy);
        chk("frame_done", pif.frame_done, e_fd);
        chk("clear_done", pif.clear_done, e_cd);
        chk("sof_err", pif.sof_err, e_se);
        if (pif.fb_write) wr_cnt++;
        if (pif.frame_done) fd_cnt++;
        if (pif.clear_done) cd_cnt++;
        if (pif.sof_err) se_cnt++;
        if (pif.busy) busy_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        pif.pix_valid = 0; pif.pix_data = 0; pif.pix_sof = 0;
        pif.clear_req = 0; pif.clear_value = 0;
        reset = 1'b1;
        #2;
        chk("rst_fb_write", pif.fb_write, 0);
        chk("rst_fb_address", pif.fb_address, 0);
        chk("rst_fb_writedata", pif.fb_writedata, 0);
        chk("rst_busy", pif.busy, 0);
        chk("rst_pulses", {pif.frame_done, pif.clear_done, pif.sof_err}, 0);
        @(posedge clk50);
        #1;
        reset = 1'b0;
        model_reset();
        clr_counts();
        #1;
        chk("rel_pix_ready", pif.pix_ready, 1);
    endtask

    initial begin
        model_reset();
        clr_counts();
        do_reset();

        // Alternating 1,0,... from sof
        for (int i = 0; i < 32; i++) cyc(1, (i % 2) == 0, i == 0, 0, 0);
        chk("alt_write", pif.fb_write, 1);
        chk("alt_data", pif.fb_writedata, 32'h5555_5555);
        chk("alt_sof_err", se_cnt, 0);

        // Full frame of white pixels, then one more word
        do_reset();
        for (int i = 0; i < FRAME; i++) cyc(1, 1, i == 0, 0, 0);
        chk("frame_writes", wr_cnt, WORDS);
        chk("frame_done_cnt", fd_cnt, 1);
        for (int i = 0; i < 32; i++) cyc(1, 1, 0, 0, 0);
        chk("wrap_addr", pif.fb_address, 0);

        // Misaligned sof after 10 words + 7 pixels
        do_reset();
        for (int i = 0; i < 10 * 32 + 7; i++)
            cyc(1, 1'($urandom), i == 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("sof_err_pulse", pif.sof_err, 1);
        chk("sof_no_write", pif.fb_write, 0);
        for (int i = 0; i < 31; i++) cyc(1, 1'($urandom), 0, 0, 0);
        chk("sof_word_addr", pif.fb_address, 0);

        // Clear with value 1 after 5 pixels
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 1, i == 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        clr_counts();
        idle(WORDS + 3);
        chk("clr_busy_cycles", busy_cnt, WORDS - 1);
        chk("clr_writes", wr_cnt, WORDS - 1);
        chk("clr_done_cnt", cd_cnt, 1);
        for (int i = 0; i < 32; i++) cyc(1, 1'($urandom), 0, 0, 0);
        chk("post_clr_addr", pif.fb_address, 0);

        // Clear against a word-completing pixel, with a mid-clear request
        do_reset();
        for (int i = 0; i < 31; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("clr_vs_px_addr", pif.fb_address, 0);
        idle(10);
        cyc(1, 1, 0, 1, 1);
        clr_counts();
        idle(WORDS);
        chk("mid_clr_ignored", cd_cnt, 1);

        // Pending stream write followed directly by a clear
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(WORDS + 2);

        // Reset in the middle of a clear
        cyc(0, 0, 0, 1, 1);
        idle(20);
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1, 1'($urandom), 0, 0, 0);
        chk("post_rst_addr", pif.fb_address, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 200) == 0,
                ($urandom % 1500) == 0, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_pixel_packer.md
Name: fb_pixel_packer

Overview:
- Upstream feeder for the 640x480 1-bpp VGA framebuffer peripheral.
- Accepts a row-major stream of 1-bit pixels via valid/ready, packs them 32 per word, and issues single-cycle framebuffer writes (write/address/writedata) that connect directly to the framebuffer's write port.
- Also provides a hardware full-screen clear that fills every word with a constant.

Parameters:
- WORDS, 9600, framebuffer words per frame (640*480/32).
- ADDR_W, 15, framebuffer word-address width.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel present on pix_data.
- pix_data  in  1  pixel value; 1 = white, 0 = black.
- pix_sof  in  1  qualifies pix_data as pixel 0 of a frame (top-left).
- pix_ready  out  1  block can accept a pixel this cycle.
- clear_req  in  1  single-cycle request to fill the whole frame.
- clear_value  in  1  fill value, sampled in the cycle clear_req is accepted.
- fb_write  out  1  one-cycle write strobe to framebuffer.
- fb_address  out  ADDR_W  word address, 0..WORDS-1.
- fb_writedata  out  32  packed pixel word.
- busy  out  1  high while in CLEAR.
- frame_done  out  1  one-cycle pulse after word WORDS-1 is written in STREAM.
- clear_done  out  1  one-cycle pulse after the last CLEAR write.
- sof_err  out  1  one-cycle pulse when pix_sof arrives out of frame alignment.

Behaviour:
- Reset: state=STREAM; bit count=0; word address=0; shift register=0; fill latch=0. Outputs: fb_write=0, fb_address=0, fb_writedata=0, busy=0, frame_done=0, clear_done=0, sof_err=0. pix_ready=1 as soon as reset deasserts.
- Reset asserted mid-operation immediately returns to the reset state. A partial word or an in-progress clear is abandoned with no further writes.
- Accept: a pixel is accepted when pix_valid && pix_ready. pix_ready = (state==STREAM) && !clear_req.
- Packing: accepted pixel k (k = 0..31 within the word) goes to bit k, so bit 0 is the leftmost pixel. The bit count is 5 bits and wraps 31->0.
- Write timing: when the 32nd pixel is accepted in cycle N:
  - fb_write=1 in cycle N+1.
  - fb_writedata holds all 32 pixels.
  - fb_address holds the current word address.
  - The word address increments after the write.
- Throughput: back-to-back accepts every cycle sustain one write per 32 cycles with no stall.
- Outputs are registered. fb_address and fb_writedata hold their last values when fb_write=0.
- Frame wrap: the write to address WORDS-1 is followed by address 0. frame_done pulses in the same cycle as that write.
- pix_sof handling:
  - If pix_sof is accepted while bit count=0 and address=0, the pixel is processed normally.
  - Otherwise: sof_err pulses in the next cycle, the partial word is discarded (no write), and the address is forced to 0. The sof pixel then becomes bit 0 of word 0.
- pix_sof is ignored when the pixel is not accepted.
- FSM states: STREAM, CLEAR.
- STREAM->CLEAR: on clear_req=1, whatever the bit count.
  - Any partial word is discarded.
  - clear_value is latched.
  - The clear counter is set to 0.
  - No pixel is accepted that cycle.
- In CLEAR:
  - pix_ready=0 and busy=1.
  - One write per cycle: fb_write=1, fb_address = clear counter, fb_writedata = {32{latched value}}.
  - The clear counter runs 0..WORDS-1, and the first write is the cycle after acceptance.
  - clear_req is ignored while in CLEAR.
- CLEAR->STREAM: after the write to WORDS-1.
  - clear_done pulses with that last write.
  - Bit count=0 and address=0.
  - busy=0 and pix_ready=1 in the following cycle.
  - frame_done does not pulse for a clear.
- Simultaneous clear_req and a word-completing pixel: clear wins. The pixel is not accepted (pix_ready=0) and no stream write is issued. A write already scheduled from the prior cycle's completion still occurs, and CLEAR writes start the cycle after it.
- Arithmetic: address and clear counter are ADDR_W bits, compared against WORDS-1 for wrap. Values >= WORDS are never emitted.

Test Plan:
- Reset, then 32 accepted pixels alternating 1,0,... starting with pix_sof=1 -> one fb_write, address 0, data 0x55555555, one cycle after the 32nd accept. No sof_err.
- Stream a full frame of 307200 pixels every cycle, all 1 -> 9600 writes of 0xFFFFFFFF at addresses 0..9599 at a 32-cycle spacing. frame_done coincides with the address 9599 write, and the next word goes to address 0.
- After 10 words plus 7 pixels, assert pix_sof -> sof_err pulse, no write for the partial word. The next 32 pixels write to address 0.
- clear_req with clear_value=1 after 5 pixels -> pix_ready=0 and busy=1 for 9600 cycles, writes of 0xFFFFFFFF at 0..9599 on consecutive cycles, clear_done on the last. The next stream word lands at address 0 containing only new pixels.
- clear_req in the same cycle as a word-completing pixel with pix_valid=1 -> that pixel is not accepted. The CLEAR sequence starts at address 0, and a clear_req pulsed mid-CLEAR has no effect.
- Assert reset at CLEAR address 4000 -> fb_write=0 immediately, all outputs at reset values, pix_ready=1 after release, and the next word writes to address 0.
